// File: rtl/step_pulse_gen.sv
// Stepper driver front end: turns a period/direction/enable request into timed STEP/DIR/EN_n.
// Tracks a signed step position; enforces pulse width, DIR setup and a minimum period.
module step_pulse_gen #(
    parameter int WIDTH_WORK = 16,
    parameter int PULSE_HIGH = 50,
    parameter int DIR_SETUP  = 25,
    parameter int MIN_PERIOD = 100,
    parameter int WIDTH_POS  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH_WORK-1:0] period_AUTO,
    input  logic                 dir_AUTO,
    input  logic                 drv_en_SM,
    output logic                 step,
    output logic                 dir,
    output logic                 en_n,
    output logic [WIDTH_POS-1:0] position,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIR_CHG = 2'd1,
        HIGH    = 2'd2,
        LOW     = 2'd3
    } state_t;

    localparam logic [WIDTH_WORK-1:0] MIN_P     = WIDTH_WORK'(MIN_PERIOD);
    localparam logic [WIDTH_WORK-1:0] HIGH_LAST = WIDTH_WORK'(PULSE_HIGH - 1);
    localparam logic [WIDTH_WORK-1:0] DIR_LAST  = WIDTH_WORK'(DIR_SETUP - 1);
    localparam logic [WIDTH_WORK-1:0] PH_W      = WIDTH_WORK'(PULSE_HIGH);
    localparam logic [WIDTH_WORK-1:0] ONE_W     = WIDTH_WORK'(1);
    localparam logic [WIDTH_POS-1:0]  ONE_P     = WIDTH_POS'(1);

    state_t                state_q, state_d;
    logic [WIDTH_WORK-1:0] timer_q, timer_d;
    logic [WIDTH_WORK-1:0] period_q, period_d;
    logic                  dir_q, dir_d;
    logic [WIDTH_POS-1:0]  pos_q, pos_d;
    logic                  step_q;
    logic                  en_n_q;

    logic                  go;
    logic                  decide;
    logic [WIDTH_WORK-1:0] period_clamped;
    logic [WIDTH_WORK-1:0] low_last;
    logic [WIDTH_POS-1:0]  pos_next;

    assign go             = drv_en_SM && (period_AUTO != '0);
    assign period_clamped = (period_AUTO < MIN_P) ? MIN_P : period_AUTO;
    assign low_last       = period_q - PH_W - ONE_W;
    assign pos_next       = dir_q ? (pos_q + ONE_P) : (pos_q - ONE_P);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + ONE_W;
        period_d = period_q;
        dir_d    = dir_q;
        pos_d    = pos_q;
        decide   = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                decide  = 1'b1;
            end
            DIR_CHG: begin
                if (timer_q == DIR_LAST) begin
                    timer_d = '0;
                    state_d = HIGH;
                    pos_d   = pos_next;
                end
            end
            HIGH: begin
                // A pulse always completes; a dropped enable only ends the train afterwards.
                if (timer_q == HIGH_LAST) begin
                    timer_d = '0;
                    state_d = drv_en_SM ? LOW : IDLE;
                end
            end
            LOW: begin
                if (!drv_en_SM) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else if (timer_q == low_last) begin
                    timer_d = '0;
                    decide  = 1'b1;
                end
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase

        // Period and direction are sampled only here, so mid-period input changes wait.
        if (decide) begin
            if (go) begin
                period_d = period_clamped;
                if (dir_AUTO != dir_q) begin
                    dir_d   = dir_AUTO;
                    state_d = DIR_CHG;
                end else begin
                    state_d = HIGH;
                    pos_d   = pos_next;
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            period_q <= '0;
            dir_q    <= 1'b0;
            pos_q    <= '0;
            step_q   <= 1'b0;
            en_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            period_q <= period_d;
            dir_q    <= dir_d;
            pos_q    <= pos_d;
            step_q   <= (state_d == HIGH);
            en_n_q   <= ~(drv_en_SM | busy);
        end
    end

    assign busy     = (state_q != IDLE);
    assign step     = step_q;
    assign dir      = dir_q;
    assign en_n     = en_n_q;
    assign position = pos_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: timing of STEP/DIR/EN_n and position against hand-computed values.
module tb_step_pulse_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] period_AUTO;
    logic        dir_AUTO;
    logic        drv_en_SM;
    logic        step;
    logic        dir;
    logic        en_n;
    logic [31:0] position;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int nrise = 0;
    int rise_c [0:63];
    int fall_c = 0;
    int dchg_c = 0;
    logic step_p = 1'b0;
    logic dir_p  = 1'b0;

    step_pulse_gen dut (
        .clk        (clk),
        .rst        (rst),
        .period_AUTO(period_AUTO),
        .dir_AUTO   (dir_AUTO),
        .drv_en_SM  (drv_en_SM),
        .step       (step),
        .dir        (dir),
        .en_n       (en_n),
        .position   (position),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (step && !step_p) begin
            rise_c[nrise] = cyc;
            nrise++;
        end
        if (!step && step_p) fall_c = cyc;
        if (dir !== dir_p) dchg_c = cyc;
        step_p = step;
        dir_p  = dir;
    endtask

    task automatic wait_rise();
        int n0;
        n0 = nrise;
        for (int i = 0; i < 1000 && nrise == n0; i++) tick();
        chk("rise_timeout", 32'(nrise != n0), 32'd1);
    endtask

    task automatic wait_fall();
        int f0;
        f0 = fall_c;
        for (int i = 0; i < 1000 && fall_c == f0; i++) tick();
        chk("fall_timeout", 32'(fall_c != f0), 32'd1);
    endtask

    initial begin
        int n0;
        rst = 1'b1; period_AUTO = '0; dir_AUTO = 1'b0; drv_en_SM = 1'b0;
        repeat (3) tick();
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_en_n", 32'(en_n), 32'd1);
        chk("rst_pos", position, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_en_n", 32'(en_n), 32'd1);

        // Basic stepping, negative direction, period 200
        dir_AUTO = 1'b0; period_AUTO = 16'd200; drv_en_SM = 1'b1;
        chk("pre_go_step", 32'(step), 32'd0);
        tick();
        chk("first_rise_lat", 32'(step), 32'd1);
        chk("first_pos", position, -32'sd1);
        chk("first_busy", 32'(busy), 32'd1);
        wait_rise();
        chk("high_width", 32'(fall_c - rise_c[0]), 32'd50);
        chk("period_1", 32'(rise_c[1] - rise_c[0]), 32'd200);
        for (int i = 2; i < 5; i++) begin
            wait_rise();
            chk("period_basic", 32'(rise_c[i] - rise_c[i-1]), 32'd200);
        end
        chk("pos_after5", position, -32'sd5);
        chk("en_n_run", 32'(en_n), 32'd0);

        // Direction reversal mid-LOW
        repeat (100) tick();
        dir_AUTO = 1'b1;
        chk("dir_held", 32'(dir), 32'd0);
        wait_rise();
        chk("dir_chg_time", 32'(dchg_c - rise_c[4]), 32'd200);
        chk("rev_period", 32'(rise_c[5] - rise_c[4]), 32'd225);
        chk("dir_setup", 32'(rise_c[5] - dchg_c), 32'd25);
        chk("rev_pos", position, -32'sd4);
        wait_rise();
        chk("rev_period2", 32'(rise_c[6] - rise_c[5]), 32'd200);
        chk("rev_pos2", position, -32'sd3);

        // Period change 200 -> 400 mid-LOW
        repeat (100) tick();
        period_AUTO = 16'd400;
        wait_rise();
        chk("pchg_keep", 32'(rise_c[7] - rise_c[6]), 32'd200);
        wait_rise();
        chk("pchg_new", 32'(rise_c[8] - rise_c[7]), 32'd400);

        // Clamp: request 30, floor at 100
        repeat (100) tick();
        period_AUTO = 16'd30;
        wait_rise();
        chk("clamp_keep", 32'(rise_c[9] - rise_c[8]), 32'd400);
        wait_rise();
        chk("clamp_period", 32'(rise_c[10] - rise_c[9]), 32'd100);
        wait_fall();
        chk("clamp_high", 32'(fall_c - rise_c[10]), 32'd50);
        wait_rise();
        chk("clamp_period2", 32'(rise_c[11] - rise_c[10]), 32'd100);
        chk("clamp_pos", position, 32'd2);

        // Enable drop during HIGH cycle 10
        repeat (9) tick();
        drv_en_SM = 1'b0;
        tick();
        chk("drop_step_held", 32'(step), 32'd1);
        chk("drop_en_n_held", 32'(en_n), 32'd0);
        wait_fall();
        chk("drop_high", 32'(fall_c - rise_c[11]), 32'd50);
        chk("drop_idle", 32'(busy), 32'd0);
        chk("drop_en_n_lag", 32'(en_n), 32'd0);
        tick();
        chk("drop_en_n", 32'(en_n), 32'd1);
        n0 = nrise;
        repeat (300) tick();
        chk("drop_no_pulse", 32'(nrise), 32'(n0));
        chk("drop_pos", position, 32'd2);

        // Reset during HIGH cycle 20, then restart
        period_AUTO = 16'd200; dir_AUTO = 1'b1; drv_en_SM = 1'b1;
        tick();
        chk("re_rise", 32'(step), 32'd1);
        chk("re_pos", position, 32'd3);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_step", 32'(step), 32'd0);
        chk("mid_rst_pos", position, 32'd0);
        chk("mid_rst_en_n", 32'(en_n), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_dir", 32'(dir), 32'd0);
        rst = 1'b0; dir_AUTO = 1'b0;
        n0 = nrise;
        tick();
        chk("rst_restart_rise", 32'(step), 32'd1);
        chk("rst_restart_pos", position, -32'sd1);
        chk("rst_restart_en_n", 32'(en_n), 32'd0);
        wait_rise();
        chk("rst_restart_period", 32'(rise_c[n0 + 1] - rise_c[n0]), 32'd200);
        chk("rst_restart_pos2", position, -32'sd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
